// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, M-extension divide op encodings and divider states
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} div_state_t;
endpackage

// File: rtl/divider_unit.sv
// divider_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module divider_unit #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [4:0]      rd_in,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);
  import riscv_pkg::*;
  div_state_t state;
  logic [5:0] cnt;
  logic [XLEN-1:0] quo, rem, dvs;
  logic rem_op, neg_q, neg_r;
  logic is_signed, ovf, special;
  logic [XLEN-1:0] special_res, abs_a, abs_b, fixed_res;
  logic [XLEN:0] rem_sh, diff;
  // accept-time decode: magnitudes and the two early-exit cases
  always_comb begin
    is_signed   = ~op[0];
    ovf         = is_signed && opa == {1'b1, {(XLEN-1){1'b0}}} && opb == '1;
    special     = opb == '0 || ovf;
    special_res = opb == '0 ? (op[1] ? opa : '1) : (op[1] ? '0 : opa);
    abs_a       = is_signed && opa[XLEN-1] ? -opa : opa;
    abs_b       = is_signed && opb[XLEN-1] ? -opb : opb;
  end
  // one restoring step: shift in next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    rem_sh    = {rem, quo[XLEN-1]};
    diff      = rem_sh - {1'b0, dvs};
    fixed_res = rem_op ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  end
  // control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      result       <= '0;
      rd_out       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      start_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (start_valid) begin
          rem_op      <= op[1];
          rd_out      <= rd_in;
          neg_q       <= is_signed && (opa[XLEN-1] ^ opb[XLEN-1]);
          neg_r       <= is_signed && opa[XLEN-1];
          quo         <= abs_a;
          dvs         <= abs_b;
          rem         <= '0;
          cnt         <= '0;
          busy        <= 1'b1;
          start_ready <= 1'b0;
          if (special) begin
            result       <= special_res;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else state <= S_CALC;
        end
        S_CALC: begin
          rem   <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          quo   <= {quo[XLEN-2:0], ~diff[XLEN]};
          cnt   <= cnt + 6'd1;
          state <= cnt == 6'd31 ? S_FIX : S_CALC;
        end
        S_FIX: begin
          result       <= fixed_res;
          result_valid <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: if (result_ready) begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          start_ready  <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end
endmodule
